ser2par_capture: RTL and testbench

//   Downstream consumer of the transmission-gate D flip-flop stage. Samples its

---
 rtl/ser2par_capture.sv | 105 ++++++++++
 tb/tb_ser2par_capture.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ser2par_capture.sv
// Serial-to-parallel capture: assembles WIDTH-bit words from a strobed serial bit
// stream and hands them off on a valid/ready port. Optional parity check: PARITY_CHK_EN.
module ser2par_capture #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1,
`ifdef PARITY_CHK_EN
    localparam int FL       = WIDTH + 1,
`else
    localparam int FL       = WIDTH,
`endif
    localparam int CW       = $clog2(FL)
) (
    input  logic             ck,
    input  logic             rn,
    input  logic             d,
    input  logic             en,
    input  logic             sof,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    input  logic             ready,
    output logic             ovf,
    input  logic             ovf_clr,
    output logic [CW-1:0]    cnt
`ifdef PARITY_CHK_EN
    ,
    output logic             perr
`endif
);

    localparam logic [CW-1:0] LAST_CNT = CW'(FL - 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_base;
    logic [WIDTH-1:0] sr_shift;
    logic [WIDTH-1:0] word;
    logic             last;
    logic             store_bit;
`ifdef PARITY_CHK_EN
    logic             par_err;
`endif

    always_comb begin
        sr_base = sof ? '0 : sr;
        if (LSB_FIRST)
            sr_shift = {d, sr_base[WIDTH-1:1]};
        else
            sr_shift = {sr_base[WIDTH-2:0], d};
        last = en && !sof && (cnt == LAST_CNT);
`ifdef PARITY_CHK_EN
        // The parity bit is the last of the frame and never enters the shift register.
        store_bit = sof || (cnt < CW'(WIDTH));
        word      = sr;
        par_err   = (^sr) ^ d;
`else
        store_bit = 1'b1;
        word      = sr_shift;
`endif
    end

    always_ff @(posedge ck or negedge rn) begin
        if (!rn) begin
            sr    <= '0;
            cnt   <= '0;
            q     <= '0;
            valid <= 1'b0;
            ovf   <= 1'b0;
`ifdef PARITY_CHK_EN
            perr  <= 1'b0;
`endif
        end else begin
            if (en) begin
                if (store_bit)
                    sr <= sr_shift;
                if (sof)
                    cnt <= CW'(1);
                else if (last)
                    cnt <= '0;
                else
                    cnt <= cnt + CW'(1);
            end else if (sof) begin
                sr  <= '0;
                cnt <= '0;
            end

            if (last) begin
                if (!valid || ready) begin
                    q     <= word;
                    valid <= 1'b1;
`ifdef PARITY_CHK_EN
                    perr  <= par_err;
`endif
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end

            // A dropped word sets the flag even when a clear arrives on the same edge.
            if (last && valid && !ready)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ser2par_capture.sv
// Self-checking bench for ser2par_capture: directed scenarios plus random traffic
// against a frame-queue reference model; LSB-first and MSB-first instances share stimulus.
module tb_ser2par_capture;

    localparam int W  = 8;
`ifdef PARITY_CHK_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif
    localparam int CW = $clog2(FL);

    logic          ck;
    logic          rn;
    logic          d;
    logic          en;
    logic          sof;
    logic          ready;
    logic          ovf_clr;
    logic [W-1:0]  q,     q_m;
    logic          valid, valid_m;
    logic          ovf,   ovf_m;
    logic [CW-1:0] cnt,   cnt_m;
`ifdef PARITY_CHK_EN
    logic          perr,  perr_m;
`endif

    ser2par_capture #(.WIDTH(W), .LSB_FIRST(1'b1)) dut (
        .ck(ck), .rn(rn), .d(d), .en(en), .sof(sof), .q(q), .valid(valid),
        .ready(ready), .ovf(ovf), .ovf_clr(ovf_clr), .cnt(cnt)
`ifdef PARITY_CHK_EN
        , .perr(perr)
`endif
    );

    ser2par_capture #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .ck(ck), .rn(rn), .d(d), .en(en), .sof(sof), .q(q_m), .valid(valid_m),
        .ready(ready), .ovf(ovf_m), .ovf_clr(ovf_clr), .cnt(cnt_m)
`ifdef PARITY_CHK_EN
        , .perr(perr_m)
`endif
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: bits of the current frame in arrival order, plus the output port state.
    bit           frame[$];
    logic [W-1:0] exp_q, exp_qm;
    logic         exp_valid, exp_ovf, exp_perr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        frame.delete();
        exp_q     = '0;
        exp_qm    = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_perr  = 1'b0;
    endfunction

    function automatic void model_edge();
        logic         fire;
        logic         drop;
        logic         par;
        logic [W-1:0] w, wm;
        fire = exp_valid && ready;
        drop = 1'b0;
        if (en) begin
            if (sof) frame.delete();
            frame.push_back(d);
        end else if (sof) begin
            frame.delete();
        end
        if (frame.size() == FL) begin
            par = 1'b0;
            w   = '0;
            wm  = '0;
            for (int i = 0; i < FL; i++) par ^= frame[i];
            for (int i = 0; i < W; i++) begin
                w[i]     = frame[i];
                wm[W-1-i] = frame[i];
            end
            frame.delete();
            if (!exp_valid || ready) begin
                exp_q     = w;
                exp_qm    = wm;
                exp_valid = 1'b1;
                exp_perr  = par;
            end else begin
                drop = 1'b1;
            end
        end else if (fire) begin
            exp_valid = 1'b0;
        end
        if (drop)
            exp_ovf = 1'b1;
        else if (ovf_clr)
            exp_ovf = 1'b0;
    endfunction

    task automatic check_all();
        chk("q",       32'(q),       32'(exp_q));
        chk("q_msb",   32'(q_m),     32'(exp_qm));
        chk("valid",   32'(valid),   32'(exp_valid));
        chk("valid_m", 32'(valid_m), 32'(exp_valid));
        chk("ovf",     32'(ovf),     32'(exp_ovf));
        chk("ovf_m",   32'(ovf_m),   32'(exp_ovf));
        chk("cnt",     32'(cnt),     32'(frame.size()));
        chk("cnt_m",   32'(cnt_m),   32'(frame.size()));
`ifdef PARITY_CHK_EN
        chk("perr",    32'(perr),    32'(exp_perr));
        chk("perr_m",  32'(perr_m),  32'(exp_perr));
`endif
    endtask

    task automatic step(input logic i_en, input logic i_d, input logic i_sof,
                        input logic i_rdy, input logic i_clr);
        en      = i_en;
        d       = i_d;
        sof     = i_sof;
        ready   = i_rdy;
        ovf_clr = i_clr;
        @(posedge ck);
        model_edge();
        #1;
        check_all();
    endtask

    // Sends v LSB first; the frame's final edge carries rdy_last, the parity bit is flipped by bad_par.
    task automatic send_word(input logic [W-1:0] v, input logic rdy_last, input logic bad_par);
        logic b;
        for (int i = 0; i < FL; i++) begin
            b = (i < W) ? v[i] : ((^v) ^ bad_par);
            step(1'b1, b, 1'b0, (i == FL - 1) ? rdy_last : 1'b0, 1'b0);
        end
    endtask

    logic [W-1:0] f0;

    initial begin
        rn = 1'b0; d = 1'b0; en = 1'b0; sof = 1'b0; ready = 1'b0; ovf_clr = 1'b0;
        model_reset();
        #12;
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_cnt", 32'(cnt), 32'h0);
        rn = 1'b1;

        // 1: basic capture
        send_word(8'hA5, 1'b0, 1'b0);
        chk("t1_q", 32'(q), 32'hA5);
        chk("t1_valid", 32'(valid), 32'h1);
        chk("t1_cnt", 32'(cnt), 32'h0);

        // 2: overrun under backpressure, then clear
        send_word(8'h3C, 1'b0, 1'b0);
        chk("t2_ovf", 32'(ovf), 32'h1);
        chk("t2_q", 32'(q), 32'hA5);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t2_ovf_clr", 32'(ovf), 32'h0);

        // 3: back-to-back handoff
        send_word(8'h3C, 1'b1, 1'b0);
        chk("t3_q", 32'(q), 32'h3C);
        chk("t3_valid", 32'(valid), 32'h1);
        chk("t3_ovf", 32'(ovf), 32'h0);

        // 4: SOF with EN restarts the frame
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_drain", 32'(valid), 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t4_cnt3", 32'(cnt), 32'h3);
        f0 = 8'hF0;
        step(1'b1, f0[0], 1'b1, 1'b0, 1'b0);
        chk("t4_cnt_sof", 32'(cnt), 32'h1);
        for (int i = 1; i < FL; i++)
            step(1'b1, (i < W) ? f0[i] : (^f0), 1'b0, 1'b0, 1'b0);
        chk("t4_q", 32'(q), 32'hF0);
        chk("t4_cnt", 32'(cnt), 32'h0);
        chk("t4_valid", 32'(valid), 32'h1);

        // 6: MSB-first instance
        send_word(8'hA5, 1'b1, 1'b0);
        chk("t6_qm_a5", 32'(q_m), 32'hA5);
        send_word(8'h01, 1'b1, 1'b0);
        chk("t6_qm_80", 32'(q_m), 32'h80);
        chk("t6_q_01", 32'(q), 32'h01);

`ifdef PARITY_CHK_EN
        // 7: parity
        send_word(8'hA5, 1'b1, 1'b0);
        chk("t7_perr0", 32'(perr), 32'h0);
        send_word(8'hA5, 1'b1, 1'b1);
        chk("t7_perr1", 32'(perr), 32'h1);
        chk("t7_q", 32'(q), 32'hA5);
        chk("t7_valid", 32'(valid), 32'h1);
`endif

        // 5: asynchronous reset mid-frame with VALID and OVF set
        send_word(8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_cnt5", 32'(cnt), 32'h5);
        chk("t5_pre_valid", 32'(valid), 32'h1);
        chk("t5_pre_ovf", 32'(ovf), 32'h1);
        #2;
        rn = 1'b0;
        #1;
        chk("t5_q", 32'(q), 32'h0);
        chk("t5_valid", 32'(valid), 32'h0);
        chk("t5_ovf", 32'(ovf), 32'h0);
        chk("t5_cnt", 32'(cnt), 32'h0);
        model_reset();
        @(negedge ck);
        rn = 1'b1;

        // Random traffic
        for (int n = 0; n < 4000; n++)
            step($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 19) == 0,
                 1'($urandom), $urandom_range(0, 19) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
